bus_demultiplexer: RTL
======================

// Module: bus_demultiplexer
// PURPOSE
//  Write-side counterpart of the processor data-bus multiplexer. Decodes the 4-bit bus-write select
//  and loads the 12-bit bus value into the selected destination register (R, IR, RL, RC, RP, RQ, R1, AC).
//  Also owns per-register increment logic and a request/acknowledge handshake for data-memory writes.
//  Sits between the control unit (selects, increments), the shared 12-bit bus and data memory.
// PARAMETERS
//  DATA_W   12  bus and register width
//  IR_W     8   instruction register width; bus[IR_W-1:0] is loaded
// PORTS
//  clk          in   1       single clock; all state updates on rising edge
//  rst          in   1       synchronous, active-high reset
//  writeSel     in   4       destination select (codes below); sampled every cycle
//  busIn        in   DATA_W  shared data bus value
//  incEn        in   4       increment strobes {R1,RQ,RP,RC}
//  aluOut       in   DATA_W  ALU result
//  acAluLd      in   1       load AC from aluOut
//  memAddr      in   DATA_W  address for DMem write, captured with the request
//  memWrAck     in   1       data memory accepted the write (single-cycle pulse)
//  R,RL,RC,RP,RQ,R1,AC out DATA_W  destination registers
//  IR           out  IR_W    instruction register
//  memWrReq     out  1       DMem write request, held until ack
//  memWrAddr    out  DATA_W  latched write address
//  memWrData    out  DATA_W  latched write data
//  busy         out  1       DMem write in progress
//  wrOverrun    out  1       one-cycle pulse: DMem write select seen while busy (dropped)
// BEHAVIOUR
//  - Select codes: 0 DMem, 1 R, 2 IR, 3 RL, 4 RC, 5 RP, 6 RQ, 7 R1, 8 AC, 9 idle; 10-15 treated as idle.
//  - Reset: all registers, memWrAddr, memWrData = 0; memWrReq, busy, wrOverrun = 0; FSM = IDLE.
//  - Register load: selected register <= busIn at the next edge (latency 1). Only one destination per cycle.
//  - IR load: IR <= busIn[IR_W-1:0]; upper bus bits ignored.
//  - Increment: incEn[i] high -> register += 1, modulo 2^DATA_W (12'hFFF -> 12'h000), no carry out.
//  - Same register loaded from bus and incremented in one cycle: bus load wins, increment dropped.
//  - AC: bus load (writeSel==8) beats acAluLd; otherwise acAluLd loads aluOut. AC has no increment.
//  - DMem FSM, 2 states:
//      IDLE: writeSel==0 -> capture busIn->memWrData, memAddr->memWrAddr; go WAIT; memWrReq=busy=1 next cycle.
//      WAIT: memWrReq, memWrAddr, memWrData held stable; memWrAck -> IDLE, memWrReq/busy low next cycle.
//      Ack in IDLE ignored. writeSel==0 in WAIT -> no capture, wrOverrun pulses next cycle.
//      Back-to-back: writeSel==0 in the ack cycle is an overrun (no same-cycle re-arm).
//  - Reset mid-handshake: FSM -> IDLE, memWrReq drops next edge, pending write abandoned.
//  - Register loads/increments proceed independently of DMem FSM state.
// STRUCTURE
//  - Shared package: select-code localparams (DMem..idle), shared with bus multiplexer so codes cannot diverge;
//    DATA_W/IR_W defaults; FSM state encoding.
//  - One sub-module: dest_reg (DATA_W register with sync reset, load, inc; load priority) instantiated
//    for R, RL, RC, RP, RQ, R1 (inc tied 0 for R, RL); AC and IR inline. DMem FSM inline.
// TESTING
//  1 rst=1 two cycles after random loads -> all outputs 0, memWrReq=0, busy=0.
//  2 writeSel=4, busIn=12'h0A5 -> RC=12'h0A5 next cycle; writeSel=2, busIn=12'hF3C -> IR=8'h3C.
//  3 RP=12'hFFF, incEn=4'b0010 -> RP=12'h000; same cycle writeSel=5, busIn=12'h123 -> RP=12'h123 (load wins).
//  4 writeSel=0, busIn=12'h456, memAddr=12'h010 -> memWrReq=1, addr 010, data 456 held 3 cycles; ack -> req=0.
//  5 In WAIT, writeSel=0 busIn=12'h777 -> wrOverrun 1-cycle pulse, memWrData stays 12'h456.
//  6 rst in WAIT with ack pending -> memWrReq=0 next edge; later ack ignored; writeSel=8 + acAluLd -> AC=busIn.

Source files
------------

// File: rtl/bus_demultiplexer_pkg.sv
// Shared definitions for the data-bus demultiplexer: widths, bus-write select codes, write FSM states.
// The bus multiplexer imports the same select codes, so the read and write sides cannot drift apart.
package bus_demultiplexer_pkg;

    localparam int unsigned DATA_W = 12;
    localparam int unsigned IR_W   = 8;
    localparam int unsigned SEL_W  = 4;

    localparam logic [SEL_W-1:0] SEL_DMEM = SEL_W'(0);
    localparam logic [SEL_W-1:0] SEL_R    = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_IR   = SEL_W'(2);
    localparam logic [SEL_W-1:0] SEL_RL   = SEL_W'(3);
    localparam logic [SEL_W-1:0] SEL_RC   = SEL_W'(4);
    localparam logic [SEL_W-1:0] SEL_RP   = SEL_W'(5);
    localparam logic [SEL_W-1:0] SEL_RQ   = SEL_W'(6);
    localparam logic [SEL_W-1:0] SEL_R1   = SEL_W'(7);
    localparam logic [SEL_W-1:0] SEL_AC   = SEL_W'(8);
    localparam logic [SEL_W-1:0] SEL_IDLE = SEL_W'(9);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } wrState_e;

endpackage

// File: rtl/bus_demultiplexer_if.sv
// Bus-write port bundle: control-unit strobes, shared bus, ALU result, data-memory handshake
// and the destination registers that the demultiplexer drives.
interface bus_demultiplexer_if #(
    parameter int unsigned dataW = bus_demultiplexer_pkg::DATA_W,
    parameter int unsigned irW   = bus_demultiplexer_pkg::IR_W
);
    import bus_demultiplexer_pkg::*;

    logic [SEL_W-1:0] writeSel;
    logic [dataW-1:0] busIn;
    logic [3:0]       incEn;
    logic [dataW-1:0] aluOut;
    logic             acAluLd;
    logic [dataW-1:0] memAddr;
    logic             memWrAck;

    logic [dataW-1:0] R;
    logic [irW-1:0]   IR;
    logic [dataW-1:0] RL;
    logic [dataW-1:0] RC;
    logic [dataW-1:0] RP;
    logic [dataW-1:0] RQ;
    logic [dataW-1:0] R1;
    logic [dataW-1:0] AC;
    logic             memWrReq;
    logic [dataW-1:0] memWrAddr;
    logic [dataW-1:0] memWrData;
    logic             busy;
    logic             wrOverrun;

    modport master (
        output writeSel, busIn, incEn, aluOut, acAluLd, memAddr, memWrAck,
        input  R, IR, RL, RC, RP, RQ, R1, AC,
        input  memWrReq, memWrAddr, memWrData, busy, wrOverrun
    );

    modport slave (
        input  writeSel, busIn, incEn, aluOut, acAluLd, memAddr, memWrAck,
        output R, IR, RL, RC, RP, RQ, R1, AC,
        output memWrReq, memWrAddr, memWrData, busy, wrOverrun
    );

endinterface

// File: rtl/bus_demultiplexer_dest_reg.sv
// Destination register with synchronous reset, bus load and wrap-around increment.
// A bus load in the same cycle as an increment wins; the increment is dropped.
module bus_demultiplexer_dest_reg #(
    parameter int unsigned width = bus_demultiplexer_pkg::DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             inc,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end else if (inc) begin
            q <= q + width'(1);
        end
    end

endmodule

// File: rtl/bus_demultiplexer.sv
// Write side of the processor data bus: decodes writeSel into one destination register load,
// applies per-register increments, and runs the request/ack handshake for data-memory writes.
module bus_demultiplexer
    import bus_demultiplexer_pkg::*;
#(
    parameter int unsigned dataW = DATA_W,
    parameter int unsigned irW   = IR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    bus_demultiplexer_if.slave   bus
);

    logic ldR, ldIR, ldRL, ldRC, ldRP, ldRQ, ldR1, ldAC, selDmem;

    wrState_e         state, stateNext;
    logic [dataW-1:0] addrNext, dataNext;
    logic             overrunNext;

    // One-hot select decode; codes 9..15 load nothing
    always_comb begin
        selDmem = (bus.writeSel == SEL_DMEM);
        ldR     = (bus.writeSel == SEL_R);
        ldIR    = (bus.writeSel == SEL_IR);
        ldRL    = (bus.writeSel == SEL_RL);
        ldRC    = (bus.writeSel == SEL_RC);
        ldRP    = (bus.writeSel == SEL_RP);
        ldRQ    = (bus.writeSel == SEL_RQ);
        ldR1    = (bus.writeSel == SEL_R1);
        ldAC    = (bus.writeSel == SEL_AC);
    end

    bus_demultiplexer_dest_reg #(.width(dataW)) uR (
        .clk(clk), .rst(rst), .ld(ldR), .inc(1'b0), .d(bus.busIn), .q(bus.R)
    );
    bus_demultiplexer_dest_reg #(.width(dataW)) uRL (
        .clk(clk), .rst(rst), .ld(ldRL), .inc(1'b0), .d(bus.busIn), .q(bus.RL)
    );
    bus_demultiplexer_dest_reg #(.width(dataW)) uRC (
        .clk(clk), .rst(rst), .ld(ldRC), .inc(bus.incEn[0]), .d(bus.busIn), .q(bus.RC)
    );
    bus_demultiplexer_dest_reg #(.width(dataW)) uRP (
        .clk(clk), .rst(rst), .ld(ldRP), .inc(bus.incEn[1]), .d(bus.busIn), .q(bus.RP)
    );
    bus_demultiplexer_dest_reg #(.width(dataW)) uRQ (
        .clk(clk), .rst(rst), .ld(ldRQ), .inc(bus.incEn[2]), .d(bus.busIn), .q(bus.RQ)
    );
    bus_demultiplexer_dest_reg #(.width(dataW)) uR1 (
        .clk(clk), .rst(rst), .ld(ldR1), .inc(bus.incEn[3]), .d(bus.busIn), .q(bus.R1)
    );

    // IR takes the low bus bits; AC prefers the bus over the ALU result
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.IR <= '0;
            bus.AC <= '0;
        end else begin
            if (ldIR) begin
                bus.IR <= bus.busIn[irW-1:0];
            end
            if (ldAC) begin
                bus.AC <= bus.busIn;
            end else if (bus.acAluLd) begin
                bus.AC <= bus.aluOut;
            end
        end
    end

    // Data-memory write FSM: next state and next output values
    always_comb begin
        stateNext   = state;
        addrNext    = bus.memWrAddr;
        dataNext    = bus.memWrData;
        overrunNext = 1'b0;
        case (state)
            ST_IDLE: begin
                if (selDmem) begin
                    stateNext = ST_WAIT;
                    addrNext  = bus.memAddr;
                    dataNext  = bus.busIn;
                end
            end
            ST_WAIT: begin
                // A new write while one is pending is dropped, even in the ack cycle
                overrunNext = selDmem;
                if (bus.memWrAck) begin
                    stateNext = ST_IDLE;
                end
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            bus.memWrReq  <= 1'b0;
            bus.busy      <= 1'b0;
            bus.wrOverrun <= 1'b0;
            bus.memWrAddr <= '0;
            bus.memWrData <= '0;
        end else begin
            state         <= stateNext;
            bus.memWrReq  <= (stateNext == ST_WAIT);
            bus.busy      <= (stateNext == ST_WAIT);
            bus.wrOverrun <= overrunNext;
            bus.memWrAddr <= addrNext;
            bus.memWrData <= dataNext;
        end
    end

endmodule
